// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network layer blocks.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int NN_CALC_LEN = 64;

  // Accumulator width that cannot overflow for n full-width products plus a bias.
  function automatic int nn_acc_len(input int wordLen, input int nInputs);
    return 2 * wordLen + $clog2(nInputs) + 1;
  endfunction

  // Rescale a Q accumulator to the word format, clamp to the signed word range, then ReLU.
  function automatic logic [NN_CALC_LEN-1:0] sat_relu(input logic signed [NN_CALC_LEN-1:0] acc,
                                                      input int wordLen,
                                                      input int fracBits);
    logic signed [NN_CALC_LEN-1:0] shifted;
    logic signed [NN_CALC_LEN-1:0] maxVal;
    shifted = acc >>> fracBits;
    maxVal  = (64'sd1 <<< (wordLen - 1)) - 64'sd1;
    if (shifted < 0)
      return '0;
    else if (shifted > maxVal)
      return maxVal;
    else
      return shifted;
  endfunction

endpackage

// File: rtl/neuron_mac_mac_unit.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module mac_unit #(
  parameter int WORD_LEN = 16,
  parameter int ACC_LEN  = 35
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [WORD_LEN-1:0] i_a,
  input  logic [WORD_LEN-1:0] i_b,
  output logic [ACC_LEN-1:0]  o_sum
);

  logic signed [2*WORD_LEN-1:0] w_product;
  logic signed [ACC_LEN-1:0]    w_productExt;
  logic signed [ACC_LEN-1:0]    w_sum;
  logic signed [ACC_LEN-1:0]    r_acc;

  assign w_product    = $signed(i_a) * $signed(i_b);
  assign w_productExt = ACC_LEN'(w_product);
  assign w_sum        = r_acc + w_productExt;
  assign o_sum        = w_sum;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_acc <= '0;
    else if (i_clear)
      r_acc <= '0;
    else if (i_enable)
      r_acc <= w_sum;
  end

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: sequences the weight BRAM, accumulates x*w, adds bias, saturates and applies ReLU.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int WORD_LEN  = 16,
  parameter int FRAC_BITS = 8,
  parameter int N_INPUTS  = 4,
  parameter int ADDR_LEN  = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                x_valid_i,
  input  logic [WORD_LEN-1:0] x_i,
  output logic                x_ready_o,
  input  logic [WORD_LEN-1:0] bias_i,
  output logic                w_ena_o,
  output logic [ADDR_LEN-1:0] w_addr_o,
  input  logic [WORD_LEN-1:0] w_data_i,
  output logic                y_valid_o,
  output logic [WORD_LEN-1:0] y_o,
  input  logic                y_ready_i,
  output logic                busy_o
);

  localparam int ACC_LEN = nn_acc_len(WORD_LEN, N_INPUTS);
  localparam logic [WORD_LEN-1:0] L_ONE = WORD_LEN'(1) << FRAC_BITS;
  localparam logic [ADDR_LEN-1:0] L_LAST_IDX = ADDR_LEN'(N_INPUTS - 1);

  state_t              r_state;
  logic [ADDR_LEN-1:0] r_idx;
  logic                r_wVld;

  logic                w_handshake;
  logic                w_macClear;
  logic                w_macEnable;
  logic [WORD_LEN-1:0] w_macA;
  logic [WORD_LEN-1:0] w_macB;
  logic [ACC_LEN-1:0]  w_accNext;
  logic [WORD_LEN-1:0] w_yNext;

  assign x_ready_o   = r_wVld;
  assign busy_o      = (r_state != IDLE);
  assign w_handshake = x_valid_i && r_wVld;
  assign w_macClear  = (r_state == IDLE) && start_i;
  assign w_macEnable = w_handshake || (r_state == BIAS);

  // Bias is folded in through the multiplier as bias * 1.0, i.e. bias <<< FRAC_BITS.
  assign w_macA = (r_state == BIAS) ? bias_i : x_i;
  assign w_macB = (r_state == BIAS) ? L_ONE  : w_data_i;

  mac_unit #(
    .WORD_LEN(WORD_LEN),
    .ACC_LEN (ACC_LEN)
  ) u_mac (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_clear (w_macClear),
    .i_enable(w_macEnable),
    .i_a     (w_macA),
    .i_b     (w_macB),
    .o_sum   (w_accNext)
  );

  assign w_yNext = WORD_LEN'(sat_relu(NN_CALC_LEN'($signed(w_accNext)), WORD_LEN, FRAC_BITS));

  // Weight data is trusted only one cycle after the address settles.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_wVld    <= 1'b0;
      w_ena_o   <= 1'b0;
      w_addr_o  <= '0;
      y_valid_o <= 1'b0;
      y_o       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state  <= MAC;
            r_idx    <= '0;
            r_wVld   <= 1'b0;
            w_ena_o  <= 1'b1;
            w_addr_o <= '0;
          end
        end
        MAC: begin
          if (w_handshake) begin
            r_wVld <= 1'b0;
            if (r_idx == L_LAST_IDX) begin
              r_state <= BIAS;
              w_ena_o <= 1'b0;
            end else begin
              r_idx    <= r_idx + 1'b1;
              w_addr_o <= r_idx + 1'b1;
            end
          end else begin
            r_wVld <= 1'b1;
          end
        end
        BIAS: begin
          r_state   <= OUT;
          y_o       <= w_yNext;
          y_valid_o <= 1'b1;
        end
        OUT: begin
          if (y_ready_i) begin
            r_state   <= IDLE;
            y_valid_o <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Single-neuron compute stage that sits directly downstream of the weight `bram`.
- Drives the BRAM read port (ena/addr) and consumes its 1-cycle-latency read data.
- Takes N signed fixed-point activations over a valid/ready stream and computes a dot product with the stored weights, then adds a bias.
- Applies saturation and ReLU, and presents one result word on a valid/ready output.

Parameters:
- WORD_LEN, 16: width of activations, weights, bias and result (signed, two's complement, Q format).
- FRAC_BITS, 8: fractional bits of the Q format shared by x, w, bias and y.
- N_INPUTS, 4: number of activations/weights per neuron; must be ≥1.
- ADDR_LEN, 2: weight BRAM address width; must satisfy 2**ADDR_LEN ≥ N_INPUTS.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; begins a neuron evaluation; ignored unless idle.
- x_valid_i  in  1  activation valid.
- x_i  in  WORD_LEN  activation, signed Q.
- x_ready_o  out  1  activation accepted when x_valid_i && x_ready_o.
- bias_i  in  WORD_LEN  bias, signed Q; sampled in BIAS state.
- w_ena_o  out  1  BRAM enable (read only; write enable is tied 0 by the parent).
- w_addr_o  out  ADDR_LEN  BRAM address = current input index.
- w_data_i  in  WORD_LEN  BRAM read data; valid one cycle after an enabled address; reads 0 when enable is low.
- y_valid_o  out  1  result valid.
- y_o  out  WORD_LEN  result, signed Q, ≥0.
- y_ready_i  in  1  result consumed when y_valid_o && y_ready_i.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
Reset values:
- State IDLE, idx=0, acc=0, w_vld=0.
- w_ena_o=0, w_addr_o=0, x_ready_o=0, y_valid_o=0, y_o=0, busy_o=0.
- Reset mid-operation aborts immediately; any partial sum is discarded.

States: IDLE → MAC → BIAS → OUT → IDLE.
- IDLE: on start_i, go to MAC with idx=0, acc=0, w_vld=0.
- MAC:
  - w_ena_o=1 and w_addr_o=idx, held continuously. Enable must stay high because the BRAM zeroes its output when disabled.
  - w_vld is set on the cycle after an address change and stays set while the address holds.
  - x_ready_o = w_vld (combinational from registered state).
  - On handshake: acc += sign-extended x_i*w_data_i (full 2*WORD_LEN product); idx++; w_vld cleared.
  - If handshake on idx = N_INPUTS-1: go to BIAS with w_ena_o=0.
- BIAS: acc += sign-extended bias_i <<< FRAC_BITS (one cycle); go to OUT.
- OUT:
  - y_o = relu(sat(acc >>> FRAC_BITS)), registered on BIAS→OUT.
  - Arithmetic shift truncates toward −inf.
  - sat clamps to [−2^(WORD_LEN−1), 2^(WORD_LEN−1)−1]; relu maps negatives to 0.
  - y_valid_o=1 and y_o held stable until y_ready_i; then IDLE with y_valid_o=0.
  - y_ready_i may already be high on OUT entry, giving a 1-cycle OUT.

Widths:
- acc width = 2*WORD_LEN + clog2(N_INPUTS) + 1, so no internal overflow.

Latency, with x_valid_i always high and y_ready_i high:
- start at cycle 0 → handshake k at cycle 2k+2 (k=0..N−1) → BIAS at 2N+1 → y_valid_o at 2N+2.
- Initiation interval: 2 cycles per input.

Boundary conditions:
- start_i while busy: ignored.
- x_valid_i while not ready: no effect, no data lost.
- x_valid_i dropping mid-vector: stalls in MAC with address held.
- N_INPUTS=1: a single handshake goes straight to BIAS.
- bias_i is not captured earlier than BIAS; the parent holds it stable through that cycle.

Decomposition:
- Package nn_pkg:
  - state_t enum {IDLE, MAC, BIAS, OUT}.
  - localparam helper for acc width.
  - function sat_relu(acc) returning WORD_LEN bits, shared with future layer blocks.
- One sub-module: mac_unit (registered multiply-accumulate with clear and enable), so it can later be retargeted to a DSP slice.
- FSM and BRAM sequencing stay in neuron_mac.

Test Plan (WORD_LEN=16, FRAC_BITS=8, N_INPUTS=4):
- Basic dot product: weights all 0x0100 (1.0), x = 0x0100, 0x0200, 0x0300, 0x0400, bias 0 → y_o=0x0A00 (10.0), y_valid_o at cycle 10 after start, w_addr_o steps 0,1,2,3.
- Negative result / ReLU: weights 0xFF00 (−1.0), x = 1.0,1.0,1.0,1.0, bias 0x0100 → acc = −3.0 → y_o=0x0000.
- Saturation: weights 0x7F00, x = 0x7F00 ×4, bias 0x7FFF → y_o=0x7FFF. Mirror case with negative weights → 0.
- Backpressure: x_valid_i toggled randomly, y_ready_i held low 5 cycles → result identical to the basic case; y_o stable while y_valid_o && !y_ready_i; w_addr_o never changes without a handshake.
- Control: start_i pulsed while busy is ignored. reset_i asserted after the 2nd handshake → all outputs at reset values the same cycle. A fresh start then yields the correct result with no leftover accumulation.
- Fractional truncation: weight 0x0080 (0.5), x = 0x0001 ×4, bias 0 → acc product sum = 0x200 >>> 8 = 0x0002.
